// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - regfile, ID/EX register and load-use hazard/flush/hold control.
// Optional DECODE_WB_BYPASS_EN: same-cycle writeback data is forwarded through the regfile read.
module decode_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 12,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vld_d,
    input  logic [31:0]       i_instr_d,
    input  logic [XLEN-1:0]   i_pc_d,
    input  logic [XLEN-1:0]   i_pc4_d,
    input  logic [CTRL_W-1:0] i_ctrl_d,
    input  logic [XLEN-1:0]   i_imm_d,
    input  logic              i_load_d,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_rd_wren_w,
    input  logic [AW-1:0]     i_rd_addr_w,
    input  logic [XLEN-1:0]   i_rd_data_w,
    output logic              o_stall_d,
    output logic              o_vld_e,
    output logic [CTRL_W-1:0] o_ctrl_e,
    output logic              o_load_e,
    output logic [XLEN-1:0]   o_rs1_data_e,
    output logic [XLEN-1:0]   o_rs2_data_e,
    output logic [XLEN-1:0]   o_imm_e,
    output logic [AW-1:0]     o_rs1_addr_e,
    output logic [AW-1:0]     o_rs2_addr_e,
    output logic [AW-1:0]     o_rd_addr_e,
    output logic [XLEN-1:0]   o_pc_e,
    output logic [XLEN-1:0]   o_pc4_e
);

    logic [XLEN-1:0]   rf_q [NREG];

    logic              vld_q, vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              load_q, load_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [AW-1:0]     rs1_addr_q, rs1_addr_d;
    logic [AW-1:0]     rs2_addr_q, rs2_addr_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;

    logic [AW-1:0]     rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0]   rs1_rdata, rs2_rdata;
    logic              lu, wb_hz, hz;
    logic              load_fields, bubble;

    assign rs1_addr = i_instr_d[15 +: AW];
    assign rs2_addr = i_instr_d[20 +: AW];
    assign rd_addr  = i_instr_d[7 +: AW];

    always_comb begin
        rs1_rdata = rf_q[rs1_addr];
        rs2_rdata = rf_q[rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (i_rd_wren_w && (i_rd_addr_w == rs1_addr)) rs1_rdata = i_rd_data_w;
        if (i_rd_wren_w && (i_rd_addr_w == rs2_addr)) rs2_rdata = i_rd_data_w;
`endif
        if (rs1_addr == '0) rs1_rdata = '0;
        if (rs2_addr == '0) rs2_rdata = '0;
    end

    assign lu = o_vld_e && o_load_e && (o_rd_addr_e != '0) && i_vld_d
             && ((o_rd_addr_e == rs1_addr) || (o_rd_addr_e == rs2_addr));

`ifdef DECODE_WB_BYPASS_EN
    assign wb_hz = 1'b0;
`else
    // Without forwarding, a same-cycle writeback to a source costs one bubble.
    assign wb_hz = i_vld_d && i_rd_wren_w && (i_rd_addr_w != '0)
                && ((i_rd_addr_w == rs1_addr) || (i_rd_addr_w == rs2_addr));
`endif

    assign hz          = lu || wb_hz;
    assign load_fields = i_flush || !i_hold;
    assign bubble      = i_flush || hz;
    assign o_stall_d   = !i_rst && !i_flush && (i_hold || hz);

    always_comb begin
        vld_d      = vld_q;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        if (load_fields) begin
            vld_d      = bubble ? 1'b0 : i_vld_d;
            ctrl_d     = (bubble || !i_vld_d) ? '0 : i_ctrl_d;
            load_d     = bubble ? 1'b0 : i_load_d;
            rs1_data_d = rs1_rdata;
            rs2_data_d = rs2_rdata;
            imm_d      = i_imm_d;
            rs1_addr_d = rs1_addr;
            rs2_addr_d = rs2_addr;
            rd_addr_d  = rd_addr;
            pc_d       = i_pc_d;
            pc4_d      = i_pc4_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            vld_q      <= 1'b0;
            ctrl_q     <= '0;
            load_q     <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            pc_q       <= '0;
            pc4_q      <= '0;
        end else begin
            if (i_rd_wren_w && (i_rd_addr_w != '0)) rf_q[i_rd_addr_w] <= i_rd_data_w;
            vld_q      <= vld_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
        end
    end

    assign o_vld_e      = vld_q;
    assign o_ctrl_e     = ctrl_q;
    assign o_load_e     = load_q;
    assign o_rs1_data_e = rs1_data_q;
    assign o_rs2_data_e = rs2_data_q;
    assign o_imm_e      = imm_q;
    assign o_rs1_addr_e = rs1_addr_q;
    assign o_rs2_addr_e = rs2_addr_q;
    assign o_rd_addr_e  = rd_addr_q;
    assign o_pc_e       = pc_q;
    assign o_pc4_e      = pc4_q;

endmodule
